// File: rtl/pcie_tl_switch_param.sv
// Parametrised transaction-layer switch: NCH input FIFOs routed to NCH output FIFOs
// by the destination field of each word, with round-robin arbitration and threshold backpressure.
module pcie_tl_switch_param #(
  parameter  int NCH   = 4,
  parameter  int DW    = 10,
  parameter  int DEPTH = 8,
  parameter  int CW    = 5,
  localparam int DSTW  = $clog2(NCH),
  localparam int AW    = $clog2(DEPTH),
  localparam int CNTW  = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [CNTW-1:0]   umbral_bajo,
  input  logic [CNTW-1:0]   umbral_alto,
  input  logic [NCH-1:0]    push_in,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH-1:0]    pop_out,
  output logic [NCH*DW-1:0] data_out,
  output logic [NCH-1:0]    valid_out,
  output logic [NCH-1:0]    almost_full_in,
  output logic [NCH-1:0]    almost_empty_out,
  output logic [NCH-1:0]    empty_out,
  input  logic              req,
  input  logic [DSTW-1:0]   idx,
  output logic [CW-1:0]     contador,
  output logic              valid,
  output logic [2:0]        state,
  output logic [NCH-1:0]    error
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  state_t          st, st_nxt;
  logic [DW-1:0]   in_mem  [NCH][DEPTH];
  logic [DW-1:0]   out_mem [NCH][DEPTH];
  logic [AW-1:0]   in_rd [NCH], in_wr [NCH], out_rd [NCH], out_wr [NCH];
  logic [CNTW-1:0] in_cnt [NCH], out_cnt [NCH];
  logic [CW-1:0]   dlv_cnt [NCH];
  logic [CNTW-1:0] thr_lo, thr_hi;
  logic [DSTW-1:0] rr;
  logic [DSTW-1:0] head_dst [NCH];
  logic [NCH-1:0]  cand, in_push, in_pop, out_push, out_pop, ovf;
  logic [NCH-1:0]  in_busy, out_busy;
  logic            gnt_vld;
  logic [DSTW-1:0] gnt_idx, gnt_dst;
  logic [DW-1:0]   gnt_word;
  logic            traffic;

  assign state   = st;
  assign traffic = (st == ST_INIT) || (st == ST_IDLE) || (st == ST_ACTIVE);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign head_dst[g] = in_mem[g][in_rd[g]][DW-1 -: DSTW];
    assign in_busy[g]  = (in_cnt[g] != '0);
    assign out_busy[g] = (out_cnt[g] != '0);
    assign cand[g]     = (st == ST_ACTIVE) && in_busy[g] &&
                         (out_cnt[head_dst[g]] < thr_hi) && (out_cnt[head_dst[g]] != FULL);
    // A full input still accepts a push when the arbiter drains it on the same edge.
    assign in_pop[g]   = gnt_vld && (gnt_idx == DSTW'(g));
    assign in_push[g]  = traffic && push_in[g] && ((in_cnt[g] != FULL) || in_pop[g]);
    assign ovf[g]      = traffic && push_in[g] && (in_cnt[g] == FULL) && !in_pop[g];
    assign out_push[g] = gnt_vld && (gnt_dst == DSTW'(g));
    assign out_pop[g]  = (st != ST_RESET) && pop_out[g] && out_busy[g];
    // Thresholds read as zero until INIT latches them; keep the flag quiet in RESET.
    assign almost_full_in[g]   = (st != ST_RESET) && (in_cnt[g] >= thr_hi);
    assign almost_empty_out[g] = (out_cnt[g] <= thr_lo);
    assign empty_out[g]        = !out_busy[g];
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && cand[rr + DSTW'(k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr + DSTW'(k);
      end
    end
  end

  assign gnt_dst  = head_dst[gnt_idx];
  assign gnt_word = in_mem[gnt_idx][in_rd[gnt_idx]];

  always_comb begin
    st_nxt = st;
    case (st)
      ST_RESET:  st_nxt = ST_INIT;
      ST_INIT:   st_nxt = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   if (init) st_nxt = ST_INIT;
                 else if (|in_busy) st_nxt = ST_ACTIVE;
      ST_ACTIVE: if (init) st_nxt = ST_INIT;
                 else if (!(|in_busy) && !(|out_busy)) st_nxt = ST_IDLE;
      ST_ERROR:  st_nxt = ST_ERROR;
      default:   st_nxt = ST_RESET;
    endcase
    if (|ovf) st_nxt = ST_ERROR;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ST_RESET;
      thr_lo   <= '0;
      thr_hi   <= '0;
      rr       <= '0;
      error    <= '0;
      contador <= '0;
      valid    <= 1'b0;
    end else begin
      st    <= st_nxt;
      error <= error | ovf;
      if (st == ST_INIT) begin
        thr_lo <= umbral_bajo;
        thr_hi <= umbral_alto;
      end
      if (gnt_vld) rr <= gnt_idx + DSTW'(1);
      valid <= (st == ST_IDLE) && req;
      if ((st == ST_IDLE) && req) contador <= dlv_cnt[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        in_rd[i]   <= '0;
        in_wr[i]   <= '0;
        in_cnt[i]  <= '0;
        out_rd[i]  <= '0;
        out_wr[i]  <= '0;
        out_cnt[i] <= '0;
        dlv_cnt[i] <= '0;
      end
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_push[i])  in_wr[i]  <= in_wr[i] + AW'(1);
        if (in_pop[i])   in_rd[i]  <= in_rd[i] + AW'(1);
        if (out_push[i]) out_wr[i] <= out_wr[i] + AW'(1);
        if (out_pop[i])  out_rd[i] <= out_rd[i] + AW'(1);
        in_cnt[i]  <= in_cnt[i] + CNTW'(in_push[i]) - CNTW'(in_pop[i]);
        out_cnt[i] <= out_cnt[i] + CNTW'(out_push[i]) - CNTW'(out_pop[i]);
        valid_out[i] <= out_pop[i];
        if (out_pop[i]) data_out[i*DW +: DW] <= out_mem[i][out_rd[i]];
        if (st == ST_INIT)   dlv_cnt[i] <= '0;
        else if (out_pop[i]) dlv_cnt[i] <= dlv_cnt[i] + CW'(1);
      end
    end
  end

  // NOTE: FIFO storage is not reset; the counts decide what is valid, so stale
  // entries are never observed and the arrays stay plain memory.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (in_push[i])  in_mem[i][in_wr[i]]   <= data_in[i*DW +: DW];
      if (out_push[i]) out_mem[i][out_wr[i]] <= gnt_word;
    end
  end

endmodule

// File: tb/tb_pcie_tl_switch_param.sv
// Directed scoreboard bench for pcie_tl_switch_param: expected output words and
// counter reads are queued at stimulus time and compared by a negedge monitor.
module tb_pcie_tl_switch_param;

  localparam int NCH  = 4;
  localparam int DW   = 10;
  localparam int CNTW = 4;
  localparam int CW   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [CNTW-1:0]   umbral_bajo, umbral_alto;
  logic [NCH-1:0]    push_in, pop_out;
  logic [NCH*DW-1:0] data_in;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    valid_out, almost_full_in, almost_empty_out, empty_out, error;
  logic              req, valid;
  logic [1:0]        idx;
  logic [CW-1:0]     contador;
  logic [2:0]        state;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [NCH][$];
  logic [CW-1:0] exp_cnt_q [$];

  pcie_tl_switch_param dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto),
    .push_in(push_in), .data_in(data_in), .pop_out(pop_out),
    .data_out(data_out), .valid_out(valid_out),
    .almost_full_in(almost_full_in), .almost_empty_out(almost_empty_out),
    .empty_out(empty_out), .req(req), .idx(idx), .contador(contador),
    .valid(valid), .state(state), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(state), 32'(target));
  endtask

  task automatic do_reset_init();
    push_in = '0;
    pop_out = '0;
    req     = 1'b0;
    init    = 1'b1;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    step();
    init = 1'b0;
    step();
    check("reinit_idle", 32'(state), 32'd2);
  endtask

  // Monitor: every presented output word must match the head of its expected queue.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (valid_out[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out%0d_unexpected: got 0x%0h expected no word", i, data_out[i*DW +: DW]);
        end else begin
          check($sformatf("out%0d_data", i), 32'(data_out[i*DW +: DW]), 32'(exp_q[i].pop_front()));
        end
      end
    end
    if (valid) begin
      if (exp_cnt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL contador_unexpected: got 0x%0h expected no read", contador);
      end else begin
        check("contador", 32'(contador), 32'(exp_cnt_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; init = 1'b0; umbral_bajo = '0; umbral_alto = '0;
    push_in = '0; pop_out = '0; data_in = '0; req = 1'b0; idx = '0;
    #1 reset = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_contador", 32'(contador), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_empty_out", 32'(empty_out), 32'hF);
    check("rst_almost_full_in", 32'(almost_full_in), 32'd0);
    check("rst_almost_empty_out", 32'(almost_empty_out), 32'hF);

    // Init sequence: 0 -> 1 -> 1 -> 2
    init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd1;
    @(posedge clk);
    #1 reset = 1'b1;
    step(); check("init_state_1", 32'(state), 32'd1);
    step(); check("init_state_2", 32'(state), 32'd1);
    init = 1'b0;
    step(); check("idle_after_init", 32'(state), 32'd2);

    // Single word 0x0C5 (dest 0) through input 2
    data_in[2*DW +: DW] = 10'h0C5; push_in = 4'b0100;
    step(); push_in = '0;
    check("t2_still_idle", 32'(state), 32'd2);
    step();
    check("t2_active", 32'(state), 32'd3);
    check("t2_out0_empty_before", 32'(empty_out[0]), 32'd1);
    step();
    check("t2_out0_nonempty", 32'(empty_out[0]), 32'd0);
    exp_q[0].push_back(10'h0C5); pop_out = 4'b0001;
    step(); pop_out = '0;
    wait_state(3'd2, 5, "t2_back_idle");

    // Four inputs to dest 1, two rounds: rr order 0..3 and stall at output count 6
    do_reset_init();
    for (int i = 0; i < NCH; i++) data_in[i*DW +: DW] = 10'h101 + 10'(11 * 16 * 0) + 10'(17 * i);
    push_in = 4'hF; step();
    for (int i = 0; i < NCH; i++) data_in[i*DW +: DW] = 10'h145 + 10'(17 * i);
    step(); push_in = '0;
    repeat (10) step();
    check("t3_active", 32'(state), 32'd3);
    check("t3_out1_nonempty", 32'(empty_out[1]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      data_in[2*DW +: DW] = 10'h181 + 10'(k); push_in = 4'b0100;
      step();
    end
    push_in = '0; step();
    check("t3_stall_backpressure", 32'(almost_full_in), 32'b0100);
    for (int i = 0; i < NCH; i++) exp_q[1].push_back(10'h101 + 10'(17 * i));
    for (int i = 0; i < NCH; i++) exp_q[1].push_back(10'h145 + 10'(17 * i));
    for (int k = 0; k < 5; k++) exp_q[1].push_back(10'h181 + 10'(k));
    pop_out = 4'b0010;
    repeat (20) step();
    pop_out = '0;
    wait_state(3'd2, 10, "t3_back_idle");

    // Overflow of input 0 behind a stalled output 0
    for (int k = 0; k < 6; k++) begin
      data_in[0 +: DW] = 10'h010 + 10'(k); push_in = 4'b0001;
      step();
    end
    push_in = '0;
    repeat (10) step();
    check("t4_stalled_active", 32'(state), 32'd3);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) begin
        check("t4_pre_ovf_state", 32'(state), 32'd3);
        check("t4_pre_ovf_error", 32'(error), 32'd0);
        check("t4_in0_almost_full", 32'(almost_full_in), 32'b0001);
      end
      data_in[0 +: DW] = 10'h020 + 10'(k); push_in = 4'b0001;
      step();
    end
    push_in = '0;
    check("t4_error_state", 32'(state), 32'd4);
    check("t4_error_flag", 32'(error), 32'b0001);
    init = 1'b1; repeat (3) step(); init = 1'b0;
    check("t4_error_sticky_state", 32'(state), 32'd4);
    check("t4_error_sticky_flag", 32'(error), 32'b0001);
    for (int k = 0; k < 6; k++) exp_q[0].push_back(10'h010 + 10'(k));
    pop_out = 4'b0001;
    repeat (8) step();
    pop_out = '0; step();
    check("t4_out0_drained", 32'(empty_out[0]), 32'd1);
    check("t4_in0_still_full", 32'(almost_full_in), 32'b0001);

    // Five pops on output 3, then counter reads in IDLE
    do_reset_init();
    for (int k = 0; k < 5; k++) begin
      data_in[1*DW +: DW] = 10'h301 + 10'(k); push_in = 4'b0010;
      step();
    end
    push_in = '0;
    repeat (8) step();
    for (int k = 0; k < 5; k++) exp_q[3].push_back(10'h301 + 10'(k));
    pop_out = 4'b1000;
    repeat (6) step();
    pop_out = '0;
    check("t5_empty_pop_no_valid", 32'(valid_out[3]), 32'd0);
    wait_state(3'd2, 5, "t5_idle");
    req = 1'b1; idx = 2'd3; exp_cnt_q.push_back(5'd5);
    step();
    idx = 2'd0; exp_cnt_q.push_back(5'd0);
    step();
    req = 1'b0;
    step();
    check("t5_valid_drops", 32'(valid), 32'd0);

    // Asynchronous reset while FIFOs hold traffic
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NCH; i++) data_in[i*DW +: DW] = 10'h200 + 10'(16 * i + k);
      push_in = 4'hF;
      step();
    end
    push_in = '0;
    repeat (3) step();
    check("t6_busy_active", 32'(state), 32'd3);
    check("t6_out2_filled", 32'(empty_out), 32'b1011);
    #3 reset = 1'b0;
    #1;
    check("t6_async_state", 32'(state), 32'd0);
    check("t6_async_empty_out", 32'(empty_out), 32'hF);
    check("t6_async_almost_empty", 32'(almost_empty_out), 32'hF);
    check("t6_async_almost_full", 32'(almost_full_in), 32'd0);
    check("t6_async_data_out", 32'(data_out), 32'd0);
    check("t6_async_valid_out", 32'(valid_out), 32'd0);
    check("t6_async_contador", 32'(contador), 32'd0);
    check("t6_async_valid", 32'(valid), 32'd0);
    check("t6_async_error", 32'(error), 32'd0);
    do_reset_init();
    check("t6_post_empty_out", 32'(empty_out), 32'hF);
    pop_out = 4'hF;
    repeat (3) step();
    pop_out = '0;
    step();

    for (int i = 0; i < NCH; i++) check($sformatf("q%0d_drained", i), 32'(exp_q[i].size()), 32'd0);
    check("cnt_q_drained", 32'(exp_cnt_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
